sipo_deser: RTL and testbench

SIPO_DESER -- requirements
Module: sipo_deser

---
 rtl/sipo_pkg.sv | 20 ++
 rtl/sipo_bit_counter.sv | 47 ++++
 rtl/sipo_deser.sv | 120 ++++++++++++
 tb/tb_sipo_deser.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sipo_pkg.sv
// Shared types and constants for the serial-to-parallel deserializer.
// Frame length depends on SIPO_DESER_PARITY_EN (adds one trailing even-parity bit).
package sipo_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } sipo_state_e;

    function automatic int frame_len(input int width);
`ifdef SIPO_DESER_PARITY_EN
        return width + 1;
`else
        return width;
`endif
    endfunction

endpackage

// File: rtl/sipo_bit_counter.sv
// Position-within-frame counter: advances per accepted bit, wraps after the
// last bit of a frame, restarts at 1 on sync with data, clears on bare sync.
module sipo_bit_counter #(
    parameter int FRAME     = 4,
    parameter int DATA_BITS = 4,
    parameter int CW        = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic step,
    input  logic restart,
    input  logic clear,
    output logic last,
    output logic data_phase,
    output logic busy_next
);

    localparam logic [CW-1:0] LAST_CNT = CW'(FRAME - 1);
    localparam logic [CW-1:0] DATA_CNT = CW'(DATA_BITS);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign last       = (count_q == LAST_CNT);
    assign data_phase = (count_q < DATA_CNT);
    assign busy_next  = (count_d != '0);

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (restart) begin
            count_d = CW'(1);
        end else if (step) begin
            count_d = last ? '0 : count_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/sipo_deser.sv
// Serial-in parallel-out deserializer with frame sync and registered output.
// Define SIPO_DESER_PARITY_EN to append and check a trailing even-parity bit.
module sipo_deser
    import sipo_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in,
    input  logic             in_valid,
    input  logic             sync,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic             busy,
    output logic             parity_err
);

    localparam int FRAME = frame_len(WIDTH);
    localparam int CW    = $clog2(FRAME + 1);

    sipo_state_e      state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] sr_base, sr_shift, word_done;
    logic             last, data_phase, busy_next;
    logic             restart, clear, shift_en, frame_done;

    assign restart    = sync & in_valid;
    assign clear      = sync & ~in_valid;
    // The parity bit occupies a frame slot but never enters the data register.
    assign shift_en   = in_valid & (sync | data_phase);
    assign frame_done = in_valid & ~sync & last;

    sipo_bit_counter #(
        .FRAME     (FRAME),
        .DATA_BITS (WIDTH),
        .CW        (CW)
    ) u_bit_counter (
        .clk        (clk),
        .rst        (rst),
        .step       (in_valid),
        .restart    (restart),
        .clear      (clear),
        .last       (last),
        .data_phase (data_phase),
        .busy_next  (busy_next)
    );

    always_comb begin
        sr_base = sync ? '0 : sr_q;
        if (MSB_FIRST) begin
            sr_shift = {sr_base[WIDTH-2:0], in};
        end else begin
            sr_shift = {in, sr_base[WIDTH-1:1]};
        end
    end

`ifdef SIPO_DESER_PARITY_EN
    logic parity_err_q, parity_err_d;

    assign word_done = sr_q;

    always_comb begin
        parity_err_d = parity_err_q;
        if (frame_done) begin
            parity_err_d = (^sr_q) ^ in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= parity_err_d;
        end
    end

    assign parity_err = parity_err_q;
`else
    assign word_done  = sr_shift;
    assign parity_err = 1'b0;
`endif

    always_comb begin
        sr_d        = sr_q;
        out_d       = out_q;
        out_valid_d = frame_done;
        state_d     = busy_next ? SHIFT : IDLE;
        if (clear) begin
            sr_d = '0;
        end else if (shift_en) begin
            sr_d = sr_shift;
        end
        if (frame_done) begin
            out_d = word_done;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            sr_q        <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q == SHIFT);

endmodule

// File: tb/tb_sipo_deser.sv
// Scoreboard bench for sipo_deser: MSB-first and LSB-first instances share stimulus;
// a bit-list reference model predicts words, a negedge monitor checks outputs.
module tb_sipo_deser;

    localparam int W = 4;
`ifdef SIPO_DESER_PARITY_EN
    localparam int FRAME = W + 1;
`else
    localparam int FRAME = W;
`endif

    typedef struct packed {
        logic [W-1:0] word;
        logic         perr;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_bit = 1'b0;
    logic in_valid = 1'b0;
    logic sync_i = 1'b0;

    logic [W-1:0] out_m, out_l;
    logic ov_m, ov_l, busy_m, busy_l, pe_m, pe_l;

    int checks = 0;
    int failures = 0;

    exp_t exp_m[$];
    exp_t exp_l[$];
    logic model_bits[$];

    logic [W-1:0] hold_m = '0, hold_l = '0;
    logic [W-1:0] seen_m = '0, prev_seen_m = '0, seen_l = '0;
    logic         seen_pe = 1'b0;
    int           pulses_m = 0, pulses_l = 0;
    int           cyc = 0, last_cyc = 0, prev_cyc = 0;

    always #5 clk = ~clk;

    sipo_deser #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(rst), .in(in_bit), .in_valid(in_valid), .sync(sync_i),
        .out(out_m), .out_valid(ov_m), .busy(busy_m), .parity_err(pe_m)
    );

    sipo_deser #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .in(in_bit), .in_valid(in_valid), .sync(sync_i),
        .out(out_l), .out_valid(ov_l), .busy(busy_l), .parity_err(pe_l)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference model: collect accepted bits as a list; a full list is a frame.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            model_bits.delete();
        end else if (in_valid) begin
            if (sync_i) model_bits.delete();
            model_bits.push_back(in_bit);
            if (model_bits.size() == FRAME) begin
                exp_t em, el;
                logic par;
                par = 1'b0;
                for (int i = 0; i < FRAME; i++) par = par ^ model_bits[i];
                em.word = '0;
                el.word = '0;
                for (int i = 0; i < W; i++) begin
                    em.word[W-1-i] = model_bits[i];
                    el.word[i]     = model_bits[i];
                end
                em.perr = (FRAME > W) ? par : 1'b0;
                el.perr = em.perr;
                exp_m.push_back(em);
                exp_l.push_back(el);
                model_bits.delete();
            end
        end else if (sync_i) begin
            model_bits.delete();
        end
    end

    // Monitor: pops the scoreboard whenever a DUT presents out_valid.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            chk("rst_out_m", out_m, 0);
            chk("rst_ov_m", ov_m, 0);
            chk("rst_busy_m", busy_m, 0);
            chk("rst_pe_m", pe_m, 0);
            chk("rst_out_l", out_l, 0);
            exp_m.delete();
            exp_l.delete();
            hold_m = '0;
            hold_l = '0;
        end else begin
            chk("busy_m", busy_m, (model_bits.size() != 0));
            chk("busy_l", busy_l, (model_bits.size() != 0));
            if (ov_m) begin
                if (exp_m.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL pulse_m unexpected out=%0h required=no_pulse", out_m);
                end else begin
                    exp_t e;
                    e = exp_m.pop_front();
                    chk("word_m", out_m, e.word);
                    chk("perr_m", pe_m, e.perr);
                    hold_m = e.word;
                end
                pulses_m++;
                prev_seen_m = seen_m;
                seen_m = out_m;
                seen_pe = pe_m;
                prev_cyc = last_cyc;
                last_cyc = cyc;
            end else begin
                chk("hold_m", out_m, hold_m);
            end
            if (ov_l) begin
                if (exp_l.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL pulse_l unexpected out=%0h required=no_pulse", out_l);
                end else begin
                    exp_t e;
                    e = exp_l.pop_front();
                    chk("word_l", out_l, e.word);
                    chk("perr_l", pe_l, e.perr);
                    hold_l = e.word;
                end
                pulses_l++;
                seen_l = out_l;
            end else begin
                chk("hold_l", out_l, hold_l);
            end
        end
    end

    task automatic drive(input logic v, input logic b, input logic s);
        in_valid = v;
        in_bit   = b;
        sync_i   = s;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        sync_i   = 1'b0;
    endtask

    task automatic send_bits(input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            logic [15:0] v;
            v = bits;
            drive(1'b1, v[n-1-i], 1'b0);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int p0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(1);

`ifdef SIPO_DESER_PARITY_EN
        p0 = pulses_m;
        send_bits(16'b10111, 5);
        idle(2);
        chk("par_ok_pulses", pulses_m - p0, 1);
        chk("par_ok_word", seen_m, 4'b1011);
        chk("par_ok_perr", seen_pe, 1'b0);
        p0 = pulses_m;
        send_bits(16'b10110, 5);
        idle(2);
        chk("par_bad_pulses", pulses_m - p0, 1);
        chk("par_bad_word", seen_m, 4'b1011);
        chk("par_bad_perr", seen_pe, 1'b1);
`else
        p0 = pulses_m;
        send_bits(16'b1011, 4);
        idle(2);
        chk("s1_pulses", pulses_m - p0, 1);
        chk("s1_word", seen_m, 4'b1011);
        chk("s1_lsb_word", seen_l, 4'b1101);
        chk("s1_busy", busy_m, 1'b0);

        p0 = pulses_m;
        drive(1'b1, 1'b1, 1'b0);
        idle(1);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        idle(3);
        drive(1'b1, 1'b1, 1'b0);
        idle(2);
        chk("s2_pulses", pulses_m - p0, 1);
        chk("s2_word", seen_m, 4'b1101);

        p0 = pulses_m;
        send_bits(16'b11001001, 8);
        idle(2);
        chk("s3_pulses", pulses_m - p0, 2);
        chk("s3_first", prev_seen_m, 4'b1100);
        chk("s3_second", seen_m, 4'b1001);
        chk("s3_spacing", last_cyc - prev_cyc, 4);

        p0 = pulses_m;
        send_bits(16'b10, 2);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("s4_rst_out", out_m, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        send_bits(16'b1001, 4);
        idle(2);
        chk("s4_pulses", pulses_m - p0, 1);
        chk("s4_word", seen_m, 4'b1001);

        p0 = pulses_m;
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b1);
        send_bits(16'b101, 3);
        idle(2);
        chk("s5_pulses", pulses_m - p0, 1);
        chk("s5_word", seen_m, 4'b1101);
`endif

        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                rst = 1'b1;
                @(posedge clk);
                #1;
                rst = 1'b0;
            end else begin
                drive(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 19) == 0));
            end
        end
        idle(3);
        chk("left_m", exp_m.size(), 0);
        chk("left_l", exp_l.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
